// File: rtl/prog_buffer.sv
// Circular program-edit buffer: cursor-based append/overwrite/navigate, head pop toward a consumer.
// Optional BUFF_RDREG_EN registers the consumer output; default is first-word fall-through.
module prog_buffer #(
    parameter int unsigned           DATA_W   = 8,
    parameter int unsigned           ADDR_W   = 6,
    parameter logic [DATA_W-1:0]     END_CODE = DATA_W'(8'hFF)
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic [DATA_W-1:0]   data,
    input  logic                wre,
    input  logic                back,
    input  logic                forw,
    input  logic                read,
    output logic [DATA_W-1:0]   q,
    output logic [DATA_W-1:0]   out,
    output logic [ADDR_W:0]     count,
    output logic [ADDR_W:0]     cursor,
    output logic                empt,
    output logic                full,
    output logic                endf,
    output logic                ovf
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CW    = ADDR_W + 1;
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] head_q,   head_d;
    logic [CW-1:0]     count_q,  count_d;
    logic [CW-1:0]     cursor_q, cursor_d;
    logic [CW-1:0]     endcnt_q, endcnt_d;
    logic              endf_q,   endf_d;
    logic              ovf_q,    ovf_d;

    logic              is_empty, is_full, rd_acc, wr_en;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_word, head_word;

    assign is_empty  = (count_q == '0);
    assign is_full   = (count_q == DEPTH_C);
    assign rd_acc    = read && !is_empty;
    assign cur_addr  = head_q + ADDR_W'(cursor_q);
    assign cur_word  = mem_q[cur_addr];
    assign head_word = mem_q[head_q];

    // Command decode: an accepted read preempts all edits; then wre > back > forw.
    always_comb begin
        head_d   = head_q;
        count_d  = count_q;
        cursor_d = cursor_q;
        endcnt_d = endcnt_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        if (rd_acc) begin
            head_d  = head_q + ADDR_W'(1);
            count_d = count_q - ONE_C;
            if (cursor_q != '0) cursor_d = cursor_q - ONE_C;
            if (head_word == END_CODE) endcnt_d = endcnt_q - ONE_C;
        end else if (wre) begin
            if (cursor_q != count_q) begin
                wr_en    = 1'b1;
                cursor_d = cursor_q + ONE_C;
                if (cur_word == END_CODE && data != END_CODE)
                    endcnt_d = endcnt_q - ONE_C;
                else if (cur_word != END_CODE && data == END_CODE)
                    endcnt_d = endcnt_q + ONE_C;
            end else if (!is_full) begin
                wr_en    = 1'b1;
                count_d  = count_q + ONE_C;
                cursor_d = cursor_q + ONE_C;
                if (data == END_CODE) endcnt_d = endcnt_q + ONE_C;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (back) begin
            if (cursor_q != '0) cursor_d = cursor_q - ONE_C;
        end else if (forw) begin
            if (cursor_q < count_q) cursor_d = cursor_q + ONE_C;
        end
        endf_d = (endcnt_d != '0);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            head_q   <= '0;
            count_q  <= '0;
            cursor_q <= '0;
            endcnt_q <= '0;
            endf_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            head_q   <= head_d;
            count_q  <= count_d;
            cursor_q <= cursor_d;
            endcnt_q <= endcnt_d;
            endf_q   <= endf_d;
            ovf_q    <= ovf_d;
        end
    end

    // Append and overwrite share one address: on append the cursor equals the count.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[cur_addr] <= data;
    end

`ifdef BUFF_RDREG_EN
    logic [DATA_W-1:0] out_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)      out_q <= '0;
        else if (rd_acc) out_q <= head_word;
    end

    assign out = out_q;
`else
    assign out = is_empty ? '0 : head_word;
`endif

    assign q      = (cursor_q == count_q) ? '0 : cur_word;
    assign count  = count_q;
    assign cursor = cursor_q;
    assign empt   = is_empty;
    assign full   = is_full;
    assign endf   = endf_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_prog_buffer.sv
// Bench for prog_buffer: vector table for edit/navigation, scoreboard-checked sequences for fill, wrap, end marker and reset.
module tb_prog_buffer;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [7:0] data;
    logic       wre, back, forw, read;
    logic [7:0] q, out;
    logic [6:0] count, cursor;
    logic       empt, full, endf, ovf;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    prog_buffer dut (
        .clk(clk), .clr_n(clr_n), .data(data), .wre(wre), .back(back),
        .forw(forw), .read(read), .q(q), .out(out), .count(count),
        .cursor(cursor), .empt(empt), .full(full), .endf(endf), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    typedef struct packed {
        logic       w, b, f, r;
        logic [7:0] d;
        logic [6:0] cnt, cur;
        logic [7:0] qv, out_fw, out_rg;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int cnt, input int cur,
                             input logic [7:0] qv, input logic e, input logic o);
        chk({tag, " count"},  32'(count),  32'(cnt));
        chk({tag, " cursor"}, 32'(cursor), 32'(cur));
        chk({tag, " q"},      32'(q),      32'(qv));
        chk({tag, " empt"},   32'(empt),   32'(cnt == 0));
        chk({tag, " full"},   32'(full),   32'(cnt == 64));
        chk({tag, " endf"},   32'(endf),   32'(e));
        chk({tag, " ovf"},    32'(ovf),    32'(o));
    endtask

    task automatic drive(input logic w, input logic b, input logic f, input logic r, input logic [7:0] d);
        @(negedge clk);
        wre = w; back = b; forw = f; read = r; data = d;
        @(posedge clk);
        #2;
        wre = 1'b0; back = 1'b0; forw = 1'b0; read = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_n = 1'b0;
        #2;
        @(negedge clk);
        clr_n = 1'b1;
        sb.delete();
    endtask

    task automatic do_wr(input logic [7:0] d);
        drive(1'b1, 1'b0, 1'b0, 1'b0, d);
        sb.push_back(d);
    endtask

    // Pops the scoreboard and checks the consumer word at the point the build exposes it.
    task automatic do_rd(input string tag);
        logic [7:0] exp_w;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard underflow"}, 32'(count), 32'(0));
            return;
        end
        exp_w = sb.pop_front();
`ifndef BUFF_RDREG_EN
        chk({tag, " out fwft"}, 32'(out), 32'(exp_w));
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
`ifdef BUFF_RDREG_EN
        chk({tag, " out reg"}, 32'(out), 32'(exp_w));
`endif
    endtask

    initial begin
        clr_n = 1'b1; data = '0; wre = 0; back = 0; forw = 0; read = 0;
        #1 clr_n = 1'b0;
        #12;
        chk_state("reset", 0, 0, 8'h00, 1'b0, 1'b0);
        chk("reset out", 32'(out), 32'(0));
        @(negedge clk);
        clr_n = 1'b1;

        //          w  b  f  r  data   cnt cur q      out_fw out_rg
        vt[0]  = '{1, 0, 0, 0, 8'h11, 1,  1,  8'h00, 8'h11, 8'h00};
        vt[1]  = '{1, 0, 0, 0, 8'h22, 2,  2,  8'h00, 8'h11, 8'h00};
        vt[2]  = '{1, 0, 0, 0, 8'h33, 3,  3,  8'h00, 8'h11, 8'h00};
        vt[3]  = '{0, 1, 0, 0, 8'h00, 3,  2,  8'h33, 8'h11, 8'h00};
        vt[4]  = '{0, 1, 0, 0, 8'h00, 3,  1,  8'h22, 8'h11, 8'h00};
        vt[5]  = '{1, 0, 0, 0, 8'h55, 3,  2,  8'h33, 8'h11, 8'h00};
        vt[6]  = '{0, 0, 1, 0, 8'h00, 3,  3,  8'h00, 8'h11, 8'h00};
        vt[7]  = '{0, 0, 1, 0, 8'h00, 3,  3,  8'h00, 8'h11, 8'h00};
        vt[8]  = '{0, 0, 0, 1, 8'h00, 2,  2,  8'h00, 8'h55, 8'h11};
        vt[9]  = '{0, 1, 1, 0, 8'h00, 2,  1,  8'h33, 8'h55, 8'h11};
        vt[10] = '{1, 0, 0, 1, 8'hAA, 1,  0,  8'h33, 8'h33, 8'h55};
        vt[11] = '{0, 0, 0, 1, 8'h00, 0,  0,  8'h00, 8'h00, 8'h33};
        vt[12] = '{0, 0, 0, 1, 8'h00, 0,  0,  8'h00, 8'h00, 8'h33};
        vt[13] = '{0, 1, 0, 0, 8'h00, 0,  0,  8'h00, 8'h00, 8'h33};

        for (int i = 0; i < 14; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vt[i].w, vt[i].b, vt[i].f, vt[i].r, vt[i].d);
            chk_state(tag, int'(vt[i].cnt), int'(vt[i].cur), vt[i].qv, 1'b0, 1'b0);
`ifdef BUFF_RDREG_EN
            chk({tag, " out"}, 32'(out), 32'(vt[i].out_rg));
`else
            chk({tag, " out"}, 32'(out), 32'(vt[i].out_fw));
`endif
        end

        // End-marker tally: append and pop, then overwrite of two stored markers.
        do_reset();
        do_wr(8'h01);
        do_wr(8'hFF);
        chk("endf after FF write", 32'(endf), 32'(1));
        do_wr(8'h02);
        do_rd("endf pop01");
        chk("endf after pop 01", 32'(endf), 32'(1));
        do_rd("endf popFF");
        chk("endf after pop FF", 32'(endf), 32'(0));
        do_rd("endf pop02");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk_state("read empty", 0, 0, 8'h00, 1'b0, 1'b0);

        do_wr(8'hFF);
        do_wr(8'hFF);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h03);
        sb[1] = 8'h03;
        chk("endf one FF left", 32'(endf), 32'(1));
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h04);
        sb[0] = 8'h04;
        chk_state("all FF overwritten", 2, 1, 8'h03, 1'b0, 1'b0);
        do_rd("ovw pop0");
        do_rd("ovw pop1");

        // Fill to depth, overflow, then drain through the scoreboard.
        do_reset();
        for (int i = 0; i < 64; i++) do_wr(8'(i + 1));
        chk_state("filled", 64, 64, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h99);
        chk_state("overflow", 64, 64, 8'h00, 1'b0, 1'b1);
        do_rd("full pop");
        chk_state("after full pop", 63, 63, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 63; i++) do_rd($sformatf("drain%0d", i));
        chk_state("drained", 0, 0, 8'h00, 1'b0, 1'b1);

        // Head wrap: 70 append/read pairs with three words of backlog.
        do_reset();
        for (int i = 0; i < 3; i++) do_wr(8'(8'h70 + i));
        for (int i = 0; i < 70; i++) begin
            do_wr(8'(i) & 8'h7F);
            do_rd($sformatf("wrap%0d", i));
        end
        chk("wrap count", 32'(count), 32'(3));
        for (int i = 0; i < 3; i++) do_rd($sformatf("wrapdrain%0d", i));
        chk("wrap empt", 32'(empt), 32'(1));

        // Asynchronous reset with five words stored and flags set.
        for (int i = 0; i < 64; i++) do_wr(8'h20);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h21);
        for (int i = 0; i < 59; i++) do_rd($sformatf("pre%0d", i));
        do_wr(8'hFF);
        chk_state("pre reset", 6, 6, 8'h00, 1'b1, 1'b1);
        do_rd("pre last");
        chk("pre reset count5", 32'(count), 32'(5));
        #1 clr_n = 1'b0;
        #1;
        chk_state("async reset", 0, 0, 8'h00, 1'b0, 1'b0);
        chk("async reset out", 32'(out), 32'(0));
        sb.delete();
        @(negedge clk);
        wre = 1'b1; data = 8'hAA;
        @(posedge clk);
        #2;
        chk("wre under reset", 32'(count), 32'(0));
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #2;
        wre = 1'b0;
        sb.push_back(8'hAA);
        chk_state("first edge after reset", 1, 1, 8'h00, 1'b0, 1'b0);
        do_rd("post reset pop");
        chk("post reset empt", 32'(empt), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_buffer.md
PROG_BUFFER -- requirements
Module: prog_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 6, log2 of depth; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter END_CODE, default 8'hFF (DATA_W bits), end-of-program marker value.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-005 SHALL have port clr_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port data, input, DATA_W, word to write at the cursor.
REQ-007 SHALL have port wre, input, 1, write enable: one word per asserted cycle.
REQ-008 SHALL have port back, input, 1, move cursor one word toward the head.
REQ-009 SHALL have port forw, input, 1, move cursor one word toward the tail.
REQ-010 SHALL have port read, input, 1, consumer pop request.
REQ-011 SHALL have port q, output, DATA_W, word at the cursor; 0 when cursor==count.
REQ-012 SHALL have port out, output, DATA_W, read data toward the consumer.
REQ-013 SHALL have port count, output, ADDR_W+1, stored word count, 0..DEPTH.
REQ-014 SHALL have port cursor, output, ADDR_W+1, edit offset from head, 0..count.
REQ-015 SHALL have ports empt, full, endf, ovf, output, 1 each: empty, full, end marker stored, sticky overflow.

Function
REQ-016 SHALL store words in a circular memory addressed by head pointer plus offset, modulo DEPTH.
REQ-017 SHALL treat edit commands wre > back > forw as mutually exclusive per cycle, highest priority wins.
REQ-018 SHALL, on wre with cursor==count and !full, store data at head+count, increment count and cursor.
REQ-019 SHALL, on wre with cursor<count, overwrite the word at head+cursor, increment cursor, keep count.
REQ-020 SHALL, on wre with cursor==count and full, discard data, set ovf, leave count and cursor unchanged.
REQ-021 SHALL decrement cursor on back only if cursor>0; otherwise no change.
REQ-022 SHALL increment cursor on forw only if cursor<count; otherwise no change.
REQ-023 SHALL, on read with !empt, pop the head word, advance head (wrapping), decrement count, decrement cursor if cursor>0.
REQ-024 SHALL ignore read when empt; no state change, no error flag.
REQ-025 SHALL give read priority: any wre/back/forw in a cycle with an accepted read is ignored.
REQ-026 SHALL drive empt = (count==0) and full = (count==DEPTH) combinationally from registered count.
REQ-027 SHALL set endf when a word equal to END_CODE is written (append or overwrite).
REQ-028 SHALL clear endf when a popped word equals END_CODE, or an END_CODE word is overwritten with a non-END_CODE value, unless another END_CODE word remains stored (track number of stored END_CODE words).
REQ-029 SHALL keep ovf set until reset.
REQ-030 SHALL present q combinationally from memory at head+cursor after every edge.

Reset
REQ-031 SHALL, on clr_n low, immediately clear head, count, cursor, endf, ovf, end-code tally and registered out to 0; empt=1, full=0.
REQ-032 SHALL not require memory contents to be cleared; q and out read 0 while count==0.
REQ-033 SHALL abort any in-progress command on reset assertion mid-cycle; first command accepted on first rising edge with clr_n high.

Configuration
REQ-034 SHALL support macro BUFF_RDREG_EN.
REQ-035 SHALL, without BUFF_RDREG_EN, drive out = memory at head (first-word fall-through), 0 when empt; read latency 0.
REQ-036 SHALL, with BUFF_RDREG_EN, load out with the popped word on the accepted-read edge and hold it otherwise; read latency 1 cycle.

Verification
REQ-037 SHALL cover: reset, append 8'h11,8'h22,8'h33 -> count=3, cursor=3, q=0, out=8'h11 (FWFT).
REQ-038 SHALL cover: after REQ-037, back,back, wre 8'h55 -> count=3, cursor=2, stored sequence 11,55,33, q=8'h33.
REQ-039 SHALL cover: fill to DEPTH=64, one more wre -> full=1, ovf=1, count=64; read -> full=0, count=63, ovf stays 1.
REQ-040 SHALL cover: append 8'hFF then read until popped -> endf 1 after write, 0 after pop of FF; read on empty -> no change.
REQ-041 SHALL cover: read with wre same cycle, count=2 -> count=1, data not stored; head wrap after 70 append/read pairs keeps order.
REQ-042 SHALL cover: clr_n low mid-sequence with count=5 -> count=0, empt=1, endf=0, ovf=0 without a clock edge; with BUFF_RDREG_EN, out updates one edge after read.
